lap_log_ctrl: RTL and testbench
===============================

# lap_log_ctrl

Ring-buffer controller for chronometer lap times, sitting directly upstream of the lap-log RAM. It writes each captured lap time into an external simple dual-port RAM, tracks occupancy, and drops the oldest entry on overflow. It reads entries back oldest-first through the RAM's one-cycle registered read port. Entries leave on a valid/ready stream toward the display/UART stage.

## Interface
- RAM_WIDTH, 16, lap-time word width; must match the RAM.
- RAM_ADDR_BITS, 9, RAM address width; DEPTH = 2**RAM_ADDR_BITS entries.

- clk  in  1  single clock, all logic rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- lap_valid  in  1  one-cycle pulse: store lap_time.
- lap_time  in  RAM_WIDTH  lap value to store.
- clear  in  1  synchronous flush of the log.
- out_valid  out  1  out_data holds oldest fetched entry.
- out_ready  in  1  consumer accepts out_data.
- out_data  out  RAM_WIDTH  fetched entry.
- count  out  RAM_ADDR_BITS+1  entries still in RAM; excludes the in-flight entry.
- overflow  out  1  sticky: at least one entry was dropped.
- ram_wr_en  out  1  RAM write enable.
- ram_wr_addr  out  RAM_ADDR_BITS  RAM write address.
- ram_wr_data  out  RAM_WIDTH  RAM write data.
- ram_rd_addr  out  RAM_ADDR_BITS  RAM read address.
- ram_rd_data  in  RAM_WIDTH  RAM read data; registered, valid one cycle after the address; read-first on same-address write.

## Operation
- Write side is combinational pass-through:
  - ram_wr_en = lap_valid & ~clear.
  - ram_wr_addr = wr_ptr.
  - ram_wr_data = lap_time.
  - wr_ptr increments (mod DEPTH) on each write.
- ram_rd_addr = rd_ptr at all times.
- Read FSM has three states:
  - IDLE: if count != 0 and not clear, issue fetch (rd_ptr++, count--) and go to FETCH.
  - FETCH: capture out_data <= ram_rd_data, set out_valid, go to HOLD.
  - HOLD: on out_valid & out_ready, clear out_valid and go to IDLE.
- An entry leaves the buffer at fetch issue, so overwrite never affects the in-flight entry.
- Net count update per cycle: +1 for a write, -1 for a fetch.
- Full (count == DEPTH) with write and no fetch in the same cycle:
  - rd_ptr++.
  - count unchanged.
  - overflow <= 1.
- Full with write and fetch in the same cycle:
  - No drop; count unchanged; overflow unchanged.
  - The RAM's read-first behaviour returns the old data.
- Write while empty with no fetch (fetch needs count != 0): count becomes 1.
- clear has priority over everything:
  - wr_ptr, rd_ptr, count, overflow <= 0.
  - FSM goes to IDLE and out_valid <= 0, discarding any held entry.
  - The write in that cycle is suppressed.
- Pointer wrap is natural RAM_ADDR_BITS rollover. count never exceeds DEPTH.

## Timing
- Reset values (async on rst_n low):
  - FSM in IDLE.
  - wr_ptr, rd_ptr, count = 0.
  - out_valid, overflow = 0.
  - out_data = 0.
- Write to RAM occurs on the same edge as lap_valid; count reflects it on the next cycle.
- Latency from lap_valid edge (buffer empty, FSM idle) to out_valid high is 2 cycles: IDLE cycle, then FETCH cycle.
- out_data and out_valid are registered and stable while out_valid & ~out_ready.
- Maximum throughput is one entry per 3 cycles.

## Structure
- Shared package chrono_pkg holds:
  - the read-FSM state enum (IDLE, FETCH, HOLD);
  - default width constants LAP_WIDTH = 16 and LOG_ADDR_BITS = 9.
- The RAM is not instantiated here; the top level connects the ram_* ports to the lap-log RAM.
- No sub-module: pointers, count and FSM are inline.

## Test plan
- Reset, then a single lap_valid with lap_time = 16'h0123: ram_wr_en pulses at address 0; out_valid rises 2 cycles later with out_data = 16'h0123; count reads 1 and then 0.
- Write 3 values (A, B, C) with out_ready = 0: A is held on out_data and count = 2. Pulse out_ready each time out_valid is high: out_data follows A, B, C in order.
- With out_ready = 0, write DEPTH + 3 values 0..DEPTH+2. The first value (0) is fetched into HOLD before any drop, so the drops start at 1 and the first overflow occurs on value DEPTH+1 (RAM holds 1..DEPTH, count == DEPTH). Expected final state:
  - overflow = 1;
  - count == DEPTH;
  - drained order: 0, then 3..DEPTH+2.
- Buffer full with FSM in IDLE, lap_valid and fetch in the same cycle: overflow stays 0, and the fetched data is the pre-write entry (read-first).
- Assert clear while in HOLD, together with lap_valid: out_valid drops next cycle, count = 0, overflow = 0, and no RAM write occurs.
- Deassert rst_n mid-FETCH: all outputs return to reset values immediately. After release, a fresh write appears at address 0.

Source files
------------

// File: rtl/chrono_pkg.sv
// Shared chronometer definitions: lap-log read FSM states and default widths.
package chrono_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } rd_state_e;

    localparam int LAP_WIDTH     = 16;
    localparam int LOG_ADDR_BITS = 9;

endpackage

// File: rtl/lap_log_ctrl.sv
// Lap-log ring buffer controller: writes laps to an external SDP RAM, drops the
// oldest entry when full, and streams entries out oldest-first.
module lap_log_ctrl
    import chrono_pkg::*;
#(
    parameter int RAM_WIDTH     = LAP_WIDTH,
    parameter int RAM_ADDR_BITS = LOG_ADDR_BITS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     lap_valid,
    input  logic [RAM_WIDTH-1:0]     lap_time,
    input  logic                     clear,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [RAM_WIDTH-1:0]     out_data,
    output logic [RAM_ADDR_BITS:0]   count,
    output logic                     overflow,
    output logic                     ram_wr_en,
    output logic [RAM_ADDR_BITS-1:0] ram_wr_addr,
    output logic [RAM_WIDTH-1:0]     ram_wr_data,
    output logic [RAM_ADDR_BITS-1:0] ram_rd_addr,
    input  logic [RAM_WIDTH-1:0]     ram_rd_data
);

    localparam logic [RAM_ADDR_BITS:0]   FULL_CNT = {1'b1, {RAM_ADDR_BITS{1'b0}}};
    localparam logic [RAM_ADDR_BITS-1:0] PTR_ONE  = {{(RAM_ADDR_BITS-1){1'b0}}, 1'b1};
    localparam logic [RAM_ADDR_BITS:0]   CNT_ONE  = {{RAM_ADDR_BITS{1'b0}}, 1'b1};

    rd_state_e                state_q, state_d;
    logic [RAM_ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [RAM_ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [RAM_ADDR_BITS:0]   count_q, count_d;
    logic                     overflow_q, overflow_d;
    logic                     out_valid_q, out_valid_d;
    logic [RAM_WIDTH-1:0]     out_data_q, out_data_d;

    logic wr, full, fetch, drop;

    assign wr    = lap_valid & ~clear;
    assign full  = (count_q == FULL_CNT);
    assign fetch = (state_q == IDLE) && (count_q != '0) && !clear;
    // A fetch in the same cycle frees the slot, so only drop when nothing leaves.
    assign drop  = wr && full && !fetch;

    assign ram_wr_en   = wr;
    assign ram_wr_addr = wr_ptr_q;
    assign ram_wr_data = lap_time;
    assign ram_rd_addr = rd_ptr_q;

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign count     = count_q;
    assign overflow  = overflow_q;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        if (clear) begin
            state_d     = IDLE;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            out_valid_d = 1'b0;
        end else begin
            if (wr) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (fetch || drop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            if (wr && !fetch && !full) begin
                count_d = count_q + CNT_ONE;
            end else if (fetch && !wr) begin
                count_d = count_q - CNT_ONE;
            end
            if (drop) begin
                overflow_d = 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (fetch) begin
                        state_d = FETCH;
                    end
                end
                FETCH: begin
                    out_data_d  = ram_rd_data;
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end
                HOLD: begin
                    if (out_valid_q && out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule

// File: tb/tb_lap_log_ctrl.sv
// Scoreboard bench for lap_log_ctrl with a read-first registered RAM model.
module tb_lap_log_ctrl;

    localparam int W     = 16;
    localparam int AB    = 9;
    localparam int DEPTH = 2**AB;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          lap_valid = 1'b0;
    logic [W-1:0]  lap_time = '0;
    logic          clear = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic [AB:0]   count;
    logic          overflow;
    logic          ram_wr_en;
    logic [AB-1:0] ram_wr_addr;
    logic [W-1:0]  ram_wr_data;
    logic [AB-1:0] ram_rd_addr;
    logic [W-1:0]  ram_rd_data = '0;

    logic [W-1:0]  mem [DEPTH];
    logic [W-1:0]  exp_q [$];
    int            n_cmp = 0;
    int            n_err = 0;

    lap_log_ctrl #(.RAM_WIDTH(W), .RAM_ADDR_BITS(AB)) dut (
        .clk(clk), .rst_n(rst_n), .lap_valid(lap_valid), .lap_time(lap_time),
        .clear(clear), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .count(count), .overflow(overflow),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
        .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data)
    );

    always #5 clk = ~clk;

    // Read-first: the read samples the old word before the write lands.
    always @(posedge clk) begin
        ram_rd_data <= mem[ram_rd_addr];
        if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: an accepted beat is seen at the negedge before the accepting edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", {16'h0, out_data}, 32'hFFFF_FFFF);
            end else begin
                chk("out_data", {16'h0, out_data}, {16'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] v);
        lap_valid = 1'b1;
        lap_time  = v;
        step();
        lap_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) step();
        chk("drain_left", exp_q.size(), 0);
    endtask

    task automatic wait_valid(input int budget);
        for (int i = 0; i < budget && !out_valid; i++) step();
        chk("wait_valid", {31'h0, out_valid}, 1);
    endtask

    initial begin
        // Reset state
        #22;
        chk("rst_out_valid", {31'h0, out_valid}, 0);
        chk("rst_count", {22'h0, count}, 0);
        chk("rst_overflow", {31'h0, overflow}, 0);
        chk("rst_out_data", {16'h0, out_data}, 0);
        chk("rst_rd_addr", {23'h0, ram_rd_addr}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Single lap: write at address 0, out_valid two edges later
        lap_valid = 1'b1;
        lap_time  = 16'h0123;
        #1;
        chk("t1_wr_en", {31'h0, ram_wr_en}, 1);
        chk("t1_wr_addr", {23'h0, ram_wr_addr}, 0);
        chk("t1_wr_data", {16'h0, ram_wr_data}, 32'h0123);
        exp_q.push_back(16'h0123);
        step();
        lap_valid = 1'b0;
        chk("t1_count1", {22'h0, count}, 1);
        step();
        chk("t1_count0", {22'h0, count}, 0);
        chk("t1_not_yet_valid", {31'h0, out_valid}, 0);
        step();
        chk("t1_valid", {31'h0, out_valid}, 1);
        chk("t1_data", {16'h0, out_data}, 32'h0123);
        out_ready = 1'b1;
        drain(20);
        out_ready = 1'b0;

        // Three laps held under backpressure, then pulsed out in order
        exp_q.push_back(16'hA1A1);
        exp_q.push_back(16'hB2B2);
        exp_q.push_back(16'hC3C3);
        send(16'hA1A1);
        send(16'hB2B2);
        send(16'hC3C3);
        step();
        step();
        chk("t2_count", {22'h0, count}, 2);
        chk("t2_valid", {31'h0, out_valid}, 1);
        chk("t2_hold_data", {16'h0, out_data}, 32'hA1A1);
        for (int k = 0; k < 3; k++) begin
            wait_valid(10);
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
        drain(5);

        // Overflow: DEPTH+3 laps, drops start at value 1
        exp_q.push_back(16'd0);
        for (int i = 3; i <= DEPTH + 2; i++) exp_q.push_back(W'(i));
        for (int i = 0; i <= DEPTH + 2; i++) send(W'(i));
        step();
        step();
        chk("t3_overflow", {31'h0, overflow}, 1);
        chk("t3_count", {22'h0, count}, DEPTH);
        chk("t3_hold_data", {16'h0, out_data}, 0);
        out_ready = 1'b1;
        drain(3 * DEPTH + 100);
        out_ready = 1'b0;

        // Full with FSM idle: write and fetch together, no drop, old data read
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("t4_clr_overflow", {31'h0, overflow}, 0);
        chk("t4_clr_count", {22'h0, count}, 0);
        for (int i = 0; i <= DEPTH; i++) exp_q.push_back(W'(32'h1000 + i));
        exp_q.push_back(16'hBEEF);
        for (int i = 0; i <= DEPTH; i++) send(W'(32'h1000 + i));
        step();
        step();
        chk("t4_full_count", {22'h0, count}, DEPTH);
        chk("t4_full_overflow", {31'h0, overflow}, 0);
        chk("t4_hold_data", {16'h0, out_data}, 32'h1000);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t4_idle_valid", {31'h0, out_valid}, 0);
        send(16'hBEEF);
        chk("t4_same_cycle_count", {22'h0, count}, DEPTH);
        chk("t4_same_cycle_overflow", {31'h0, overflow}, 0);
        step();
        step();
        chk("t4_readfirst_data", {16'h0, out_data}, 32'h1001);
        out_ready = 1'b1;
        drain(3 * DEPTH + 100);
        out_ready = 1'b0;
        chk("t4_end_overflow", {31'h0, overflow}, 0);

        // Clear during HOLD together with lap_valid
        for (int i = 0; i < DEPTH + 2; i++) send(W'(32'h2000 + i));
        step();
        step();
        chk("t5_pre_overflow", {31'h0, overflow}, 1);
        chk("t5_pre_valid", {31'h0, out_valid}, 1);
        clear     = 1'b1;
        lap_valid = 1'b1;
        lap_time  = 16'hFFFF;
        #1;
        chk("t5_wr_suppressed", {31'h0, ram_wr_en}, 0);
        exp_q.delete();
        step();
        clear     = 1'b0;
        lap_valid = 1'b0;
        chk("t5_valid", {31'h0, out_valid}, 0);
        chk("t5_count", {22'h0, count}, 0);
        chk("t5_overflow", {31'h0, overflow}, 0);
        step();
        step();
        step();
        chk("t5_stays_empty", {31'h0, out_valid}, 0);
        lap_valid = 1'b1;
        lap_time  = 16'h7777;
        #1;
        chk("t5_wr_addr0", {23'h0, ram_wr_addr}, 0);
        exp_q.push_back(16'h7777);
        step();
        lap_valid = 1'b0;
        out_ready = 1'b1;
        drain(20);
        out_ready = 1'b0;

        // Async reset mid-FETCH
        send(16'h3333);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_valid", {31'h0, out_valid}, 0);
        chk("t6_count", {22'h0, count}, 0);
        chk("t6_overflow", {31'h0, overflow}, 0);
        chk("t6_out_data", {16'h0, out_data}, 0);
        chk("t6_rd_addr", {23'h0, ram_rd_addr}, 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        lap_valid = 1'b1;
        lap_time  = 16'h4444;
        #1;
        chk("t6_wr_addr0", {23'h0, ram_wr_addr}, 0);
        exp_q.push_back(16'h4444);
        step();
        lap_valid = 1'b0;
        out_ready = 1'b1;
        drain(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
